// File: rtl/cdc_burst_buf.sv
// rtl/cdc_burst_buf.sv - FIFO stream buffer that drains queued words as bursts of up to BURST words.
// Optional drop statistics (i_stat_clr, ov_drop_cnt) are built when CDC_BURST_STAT_EN is defined.
module cdc_burst_buf #(
   parameter int DW      = 8,
   parameter int AW      = 6,
   parameter int BURST   = 16,
   parameter int TIMEOUT = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [DW-1:0] iv_data,
   input  logic          i_data_wr,
`ifdef CDC_BURST_STAT_EN
   input  logic          i_stat_clr,
   output logic [15:0]   ov_drop_cnt,
`endif
   output logic [DW-1:0] ov_data,
   output logic          o_data_wr,
   output logic          o_overflow,
   output logic [AW:0]   ov_level,
   output logic          o_busy
);

   localparam int DEPTH = 1 << AW;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int BW    = $clog2(BURST + 1);
   localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] BURST_LVL = (AW+1)'(BURST);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);

   typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

   state_t        state, state_next;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [TW-1:0] tmo_cnt;
   logic [BW-1:0] beat_cnt;
   logic          full, accept, drop, rd_en, start;

   assign full   = (ov_level == DEPTH_LVL);
   assign accept = i_data_wr & ~full;
   assign drop   = i_data_wr & full;
   assign start  = (ov_level >= BURST_LVL) || ((ov_level != '0) && (tmo_cnt == TMO_MAX));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_BURST;
         S_BURST: if ((rd_en && beat_cnt == BEAT_LAST) || ov_level == '0) state_next = S_GAP;
         S_GAP:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      rd_en  = (state == S_BURST) && (ov_level != '0);
      o_busy = (state != S_IDLE);
   end

   // Storage is not reset; pointers and level alone define which entries are live.
   always_ff @(posedge i_clk) begin
      if (accept) mem[wr_ptr] <= iv_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ov_level   <= '0;
         ov_data    <= '0;
         o_data_wr  <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en)  rd_ptr <= rd_ptr + 1'b1;
         ov_level   <= ov_level + (AW+1)'(accept) - (AW+1)'(rd_en);
         o_overflow <= drop;
         o_data_wr  <= rd_en;
         if (rd_en) ov_data <= mem[rd_ptr];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_cnt  <= '0;
         beat_cnt <= '0;
      end else if (state == S_IDLE) begin
         beat_cnt <= '0;
         if (start || ov_level == '0)
            tmo_cnt <= '0;
         else if (ov_level < BURST_LVL && tmo_cnt != TMO_MAX)
            tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
         tmo_cnt <= '0;
         if (rd_en) beat_cnt <= beat_cnt + 1'b1;
      end
   end

`ifdef CDC_BURST_STAT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                           ov_drop_cnt <= '0;
      else if (i_stat_clr)                    ov_drop_cnt <= '0;
      else if (drop && ov_drop_cnt != '1)     ov_drop_cnt <= ov_drop_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_cdc_burst_buf.sv
// tb/tb_cdc_burst_buf.sv - self-checking bench for cdc_burst_buf against a queue-based reference model.
module tb_cdc_burst_buf;
   localparam int DW = 8, AW = 6, DEPTH = 64, BURST = 16, TIMEOUT = 32;

   logic          clk = 1'b0, rst_n = 1'b0, wr = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          dwr, ovf, busy;
   logic [AW:0]   lvl;
`ifdef CDC_BURST_STAT_EN
   logic          stat_clr = 1'b0;
   logic [15:0]   drop_cnt;
`endif

   always #5 clk = ~clk;

   cdc_burst_buf #(.DW(DW), .AW(AW), .BURST(BURST), .TIMEOUT(TIMEOUT)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .iv_data(din), .i_data_wr(wr),
`ifdef CDC_BURST_STAT_EN
      .i_stat_clr(stat_clr), .ov_drop_cnt(drop_cnt),
`endif
      .ov_data(dout), .o_data_wr(dwr), .o_overflow(ovf), .ov_level(lvl), .o_busy(busy)
   );

   int n_cmp = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: queue of accepted words plus burst bookkeeping
   logic [DW-1:0] q[$];
   int            mode = 0, beats = 0, tmo = 0, m_l = 0, m_drops = 0;
   logic          m_full, m_rd;
   logic          exp_wr = 1'b0, exp_ovf = 1'b0;
   logic [DW-1:0] exp_data = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         mode = 0; beats = 0; tmo = 0; m_drops = 0;
         exp_wr = 1'b0; exp_ovf = 1'b0; exp_data = '0;
      end else begin
         m_l    = q.size();
         m_full = (m_l == DEPTH);
         m_rd   = (mode == 1) && (m_l > 0);
         exp_ovf = wr && m_full;
`ifdef CDC_BURST_STAT_EN
         if (stat_clr) m_drops = 0;
         else if (wr && m_full && m_drops < 65535) m_drops++;
`endif
         exp_wr = m_rd;
         if (m_rd) exp_data = q.pop_front();
         if (wr && !m_full) q.push_back(din);
         case (mode)
            0: begin
               if (m_l >= BURST || (m_l > 0 && tmo == TIMEOUT)) begin
                  mode = 1; beats = 0; tmo = 0;
               end else if (m_l == 0) tmo = 0;
               else if (tmo < TIMEOUT) tmo++;
            end
            1: begin
               if (m_rd) begin
                  beats++;
                  if (beats == BURST) mode = 2;
               end else mode = 2;
            end
            default: mode = 0;
         endcase
      end
   end

   int obs_str = 0, obs_ovf = 0, max_lvl = 0, run = 0, max_run = 0, gap = 0, min_gap = 1000;
   logic seen = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("o_data_wr", dwr, exp_wr);
         chk("ov_data", dout, exp_data);
         chk("o_overflow", ovf, exp_ovf);
         chk("ov_level", lvl, q.size());
         chk("o_busy", busy, mode != 0);
`ifdef CDC_BURST_STAT_EN
         chk("ov_drop_cnt", drop_cnt, m_drops);
`endif
         if (ovf) obs_ovf++;
         if (int'(lvl) > max_lvl) max_lvl = lvl;
         if (dwr) begin
            obs_str++;
            if (run == 0 && seen && gap < min_gap) min_gap = gap;
            run++; gap = 0; seen = 1'b1;
            if (run > max_run) max_run = run;
         end else begin
            run = 0; gap++;
         end
      end
   end

   task automatic cyc(input logic w, input logic [DW-1:0] d);
      wr = w; din = d;
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      logic ok = 1'b0;
      for (int k = 0; k < 800; k++) begin
         cyc(1'b0, '0);
         if (lvl == 0 && !busy && !dwr) begin ok = 1'b1; break; end
      end
      chk(name, ok, 1);
   endtask

   int s_str, s_ovf, nw;
   logic w;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_state", {dwr, ovf, busy, lvl, dout}, 0);
      #2 rst_n = 1'b1;

      // T2: threshold burst
      for (int i = 0; i < 16; i++) cyc(1'b1, DW'(i));
      chk("t2_level16", lvl, 16);
      cyc(1'b0, '0);
      chk("t2_busy_no_strobe", {busy, dwr}, 2'b10);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, '0);
         chk("t2_strobe", dwr, 1);
         chk("t2_data", dout, i);
      end
      cyc(1'b0, '0);
      chk("t2_end", {busy, dwr}, 2'b00);

      // T3: timeout flush of a partial fill
      cyc(1'b1, 8'hA1); cyc(1'b1, 8'hB2); cyc(1'b1, 8'hC3);
      for (int i = 3; i <= TIMEOUT + 5; i++) begin
         cyc(1'b0, '0);
         if (i == TIMEOUT)     chk("t3_still_idle", busy, 0);
         if (i == TIMEOUT + 1) chk("t3_burst_start", {busy, dwr}, 2'b10);
         if (i == TIMEOUT + 2) chk("t3_beat0", {dwr, dout}, {1'b1, 8'hA1});
         if (i == TIMEOUT + 3) chk("t3_beat1", {dwr, dout}, {1'b1, 8'hB2});
         if (i == TIMEOUT + 4) chk("t3_beat2", {dwr, dout}, {1'b1, 8'hC3});
         if (i == TIMEOUT + 5) chk("t3_done", dwr, 0);
      end
      drain("t3_drain");

      // T1: asynchronous reset in the middle of a burst
      for (int i = 0; i < 20; i++) cyc(1'b1, DW'(8'h40 + i));
      repeat (4) cyc(1'b0, '0);
      chk("t1_mid_burst", {busy, dwr}, 2'b11);
      #2 rst_n = 1'b0;
      #1 chk("t1_outputs_zero", {dwr, ovf, busy, lvl, dout}, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      s_str = obs_str;
      repeat (30) cyc(1'b0, '0);
      chk("t1_no_strobe", obs_str - s_str, 0);
      chk("t1_level0", lvl, 0);

      // T5: continuous stream
      s_str = obs_str; s_ovf = obs_ovf;
      for (int i = 0; i < 200; i++) cyc(1'b1, DW'($urandom));
      drain("t5_drain");
      chk("t5_all_out", obs_str - s_str, 200);
      chk("t5_no_drops", obs_ovf - s_ovf, 0);
      chk("t5_max_run", max_run, 16);
      chk("t5_gap_ge1", min_gap >= 1, 1);

      // T4: sustained overload fills the FIFO and forces drops
      s_ovf = obs_ovf;
      for (int i = 0; i < 900; i++) cyc(1'b1, DW'($urandom));
      chk("t4_level_sat", max_lvl, 64);
      chk("t4_drops_seen", (obs_ovf - s_ovf) > 0, 1);
`ifdef CDC_BURST_STAT_EN
      chk("t4_drop_cnt", drop_cnt, obs_ovf - s_ovf);
      stat_clr = 1'b1;
      cyc(1'b0, '0);
      stat_clr = 1'b0;
      chk("t4_drop_cnt_clr", drop_cnt, 0);
`endif
      drain("t4_drain");

      // T6: pointer wrap with random gaps
      nw = 0;
      for (int i = 0; i < 3000 && nw < 3 * DEPTH; i++) begin
         w = ($urandom_range(0, 2) != 0);
         if (w) nw++;
         cyc(w, DW'($urandom));
      end
      drain("t6_drain");
      chk("t6_level0", lvl, 0);

      // Random traffic with varying load
      for (int p = 0; p < 6; p++) begin
         int pct = $urandom_range(5, 100);
         for (int i = 0; i < 250; i++) begin
`ifdef CDC_BURST_STAT_EN
            stat_clr = ($urandom_range(0, 49) == 0);
`endif
            cyc($urandom_range(1, 100) <= pct, DW'($urandom));
         end
      end
`ifdef CDC_BURST_STAT_EN
      stat_clr = 1'b0;
`endif
      drain("rand_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
